maxpool2x2_writer: RTL and testbench

// - Streaming 2x2/stride-2 signed max-pooling stage, directly upstream of the pooling register file.
// - Accepts one conv-output activation per cycle in raster order (row-major, top-left first).
// - Each pooled result is written into the register file through one write port (data, address, write enable).
// - A one-row line buffer holds the horizontal maxima of even rows until the matching odd row arrives.

---
 rtl/maxpool2x2_writer_if.sv | 29 ++
 rtl/maxpool2x2_writer.sv | 130 +++++++++++++
 tb/tb_maxpool2x2_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2x2_writer_if.sv
// Pixel-in / register-file-write bundle for the
// 2x2 max-pool writer.
`timescale 1ns/1ps
interface maxpool2x2_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_ctrl;
  logic [ADDR_W-1:0] wr_adrs;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_ctrl, wr_adrs,
    input  wr_data, busy, frame_done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_ctrl, wr_adrs,
    output wr_data, busy, frame_done
  );
endinterface

// File: rtl/maxpool2x2_writer.sv
// Streaming 2x2/stride-2 signed max-pool writing
// each pooled value into a register-file port.
`timescale 1ns/1ps
module maxpool2x2_writer #(
  parameter int DATA_W  = 16,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int REG_NUM = 16,
  parameter int ADDR_W  = 4
) (
  input logic clk,
  input logic nrst,
  maxpool2x2_writer_if.slave bus
);
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LN = IMG_W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;
  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ADR_END =
    ADDR_W'(REG_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVEN,
    ODD
  } state_t;

  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] lbuf [LN];
  logic [ADDR_W-1:0] adrs;
  logic [DATA_W-1:0] data;
  logic ctrl;
  logic done;
  logic ready;
  logic bsy;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic acc;
  logic col_end;
  logic row_end;
  logic [LW-1:0] lidx;
  logic signed [DATA_W-1:0] pix;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] vmax;

  // start has priority: the pixel offered with it is dropped
  assign acc     = bus.in_valid & ready & ~bus.start;
  assign pix     = $signed(bus.in_data);
  assign col_end = (col == COL_END);
  assign row_end = (row == ROW_END);
  assign lidx    = LW'(col >> 1);
  assign hmax    = smax(hold, pix);
  assign vmax    = smax(lbuf[lidx], hmax);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      hold  <= '0;
      adrs  <= '0;
      data  <= '0;
      ctrl  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b0;
      bsy   <= 1'b0;
      for (int i = 0; i < LN; i++) lbuf[i] <= '0;
    end else begin
      ctrl <= 1'b0;
      done <= 1'b0;
      if (ctrl)
        adrs <= (adrs == ADR_END) ? '0 : adrs + 1'b1;
      if (bus.start) begin
        state <= EVEN;
        col   <= '0;
        row   <= '0;
        adrs  <= '0;
        ready <= 1'b1;
        bsy   <= 1'b1;
      end else if (acc) begin
        col <= col_end ? '0 : col + 1'b1;
        if (!col[0]) hold <= pix;
        if (col_end)
          row <= row_end ? '0 : row + 1'b1;
        unique case (state)
          EVEN: begin
            if (col[0]) lbuf[lidx] <= hmax;
            if (col_end) state <= ODD;
          end
          ODD: begin
            if (col[0]) begin
              ctrl <= 1'b1;
              data <= vmax;
              done <= col_end & row_end;
            end
            if (col_end) begin
              if (row_end) begin
                state <= IDLE;
                ready <= 1'b0;
                bsy   <= 1'b0;
              end else begin
                state <= EVEN;
              end
            end
          end
          IDLE: ;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.wr_ctrl    = ctrl;
  assign bus.wr_adrs    = adrs;
  assign bus.wr_data    = data;
  assign bus.busy       = bsy;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_maxpool2x2_writer.sv
// Random/directed frames against a window-max
// reference; two DUTs (16-deep and 4-deep files).
`timescale 1ns/1ps
module tb_maxpool2x2_writer;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int W  = 8;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic nrst;
  logic start;
  logic in_valid;
  logic [DW-1:0] in_data;

  maxpool2x2_writer_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  maxpool2x2_writer_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  assign b0.start    = start;
  assign b0.in_valid = in_valid;
  assign b0.in_data  = in_data;
  assign b1.start    = start;
  assign b1.in_valid = in_valid;
  assign b1.in_data  = in_data;

  maxpool2x2_writer #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H),
    .REG_NUM(16), .ADDR_W(AW)
  ) u_dut0 (
    .clk(clk), .nrst(nrst), .bus(b0)
  );

  maxpool2x2_writer #(
    .DATA_W(DW), .IMG_W(W), .IMG_H(H),
    .REG_NUM(4), .ADDR_W(AW)
  ) u_dut1 (
    .clk(clk), .nrst(nrst), .bus(b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int adr;
    int dat;
    int done;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int pix [W*H];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wcnt = 0;
  bit exp_busy = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic mon(input int d,
                     input logic wc,
                     input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd,
                     input logic fd,
                     input logic bz,
                     input logic rd);
    exp_t e;
    int sz;
    check($sformatf("busy%0d", d), 32'(bz), 32'(exp_busy));
    check($sformatf("ready%0d", d), 32'(rd), 32'(exp_busy));
    sz = (d == 0) ? q0.size() : q1.size();
    if (wc) begin
      if (sz == 0) begin
        check($sformatf("spurious_wr%0d", d), 32'(wc), 0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check($sformatf("adrs%0d", d), 32'(wa), e.adr);
        check($sformatf("data%0d", d), 32'(wd), e.dat);
        check($sformatf("done%0d", d), 32'(fd), e.done);
        check($sformatf("lat%0d", d), cyc, e.cyc);
      end
    end else begin
      check($sformatf("done_nowr%0d", d), 32'(fd), 0);
      if (sz > 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (e.cyc <= cyc) begin
          check($sformatf("missing_wr%0d", d), 32'(wc), 1);
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, b0.wr_ctrl, b0.wr_adrs, b0.wr_data,
        b0.frame_done, b0.busy, b0.in_ready);
    mon(1, b1.wr_ctrl, b1.wr_adrs, b1.wr_data,
        b1.frame_done, b1.busy, b1.in_ready);
  end

  function automatic int wmax(input int r, input int c);
    int m;
    m = pix[(r-1)*W + c-1];
    if (pix[(r-1)*W + c] > m) m = pix[(r-1)*W + c];
    if (pix[r*W + c-1] > m) m = pix[r*W + c-1];
    if (pix[r*W + c] > m) m = pix[r*W + c];
    return m;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < W*H; i++) pix[i] = i;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < W*H; i++)
      pix[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // gmode 0: dense, 1: toggle, 2: random gaps
  task automatic run_frame(input int abort_at,
                           input int gmode);
    int n;
    int r;
    int c;
    bit ph;
    bit v;
    exp_t e;
    @(negedge clk); #1;
    start = 1'b1;
    in_valid = 1'b0;
    exp_busy = 1'b1;
    wcnt = 0;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    ph = 1'b1;
    while (n < W*H && n != abort_at) begin
      case (gmode)
        1: v = ph;
        2: v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      ph = ~ph;
      in_valid = v;
      if (v) begin
        in_data = DW'(pix[n]);
        r = n / W;
        c = n % W;
        if (r % 2 == 1 && c % 2 == 1) begin
          e.dat  = wmax(r, c) & 32'hFFFF;
          e.done = (n == W*H-1) ? 1 : 0;
          e.cyc  = cyc + 1;
          e.adr  = wcnt % 16;
          q0.push_back(e);
          e.adr  = wcnt % 4;
          q1.push_back(e);
          wcnt++;
        end
        if (n == W*H-1) exp_busy = 1'b0;
        n++;
      end
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 32'(b0.wr_ctrl), 0);
    check({tag, "_adrs"}, 32'(b0.wr_adrs), 0);
    check({tag, "_data"}, 32'(b0.wr_data), 0);
    check({tag, "_busy"}, 32'(b0.busy), 0);
    check({tag, "_rdy"}, 32'(b0.in_ready), 0);
    check({tag, "_done"}, 32'(b0.frame_done), 0);
    check({tag, "_adrs1"}, 32'(b1.wr_adrs), 0);
    check({tag, "_data1"}, 32'(b1.wr_data), 0);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    #2;
    check_zero("rst");
    @(negedge clk); #1;
    nrst = 1'b1;

    fill_ramp();
    run_frame(W*H, 0);
    fill_rand();
    run_frame(5, 0);
    nrst = 1'b0;
    #1;
    check_zero("midrst");
    exp_busy = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    nrst = 1'b1;

    fill_ramp();
    run_frame(-1, 0);

    fill_rand();
    pix[0] = -5;
    pix[1] = -3;
    pix[W] = -32768;
    pix[W+1] = -1;
    pix[2] = -2;
    pix[3] = 7;
    pix[W+2] = 32767;
    pix[W+3] = -32768;
    run_frame(-1, 0);

    fill_ramp();
    run_frame(-1, 1);

    fill_rand();
    run_frame(3*W + 3, 0);
    fill_rand();
    run_frame(-1, 2);

    fill_rand();
    run_frame(-1, 0);
    fill_rand();
    run_frame(-1, 0);

    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_frame(-1, 2);
    end

    repeat (4) @(negedge clk);
    #1;
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
